// File: rtl/match_clock_ctrl_pkg.sv
// Shared types and defaults for the match-time clock controller.
// Holds the FSM state encoding and default tick/preset constants.
package match_clock_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        PAUSED,
        OVER
    } state_t;

    localparam int TICK_DIV_DEF = 50_000_000;

    localparam logic [3:0] PRESET_H_DEF = 4'd6;
    localparam logic [3:0] PRESET_L_DEF = 4'd0;

endpackage

// File: rtl/match_clock_ctrl_if.sv
// Bundle between the game side, the controller and the time counter.
// master = controller view, slave = game/counter view.
interface match_clock_ctrl_if;

    logic       start;
    logic       pause;
    logic       tc;
    logic [3:0] countH;
    logic       loadN;
    logic       ena;
    logic [3:0] datainL;
    logic [3:0] datainH;
    logic       running;
    logic       paused;
    logic       game_over;
    logic       warn;

    modport master (
        input  start, pause, tc, countH,
        output loadN, ena, datainL, datainH,
        output running, paused, game_over, warn
    );

    modport slave (
        output start, pause, tc, countH,
        input  loadN, ena, datainL, datainH,
        input  running, paused, game_over, warn
    );

endinterface

// File: rtl/match_clock_ctrl_tick_prescaler.sv
// Modulo-TICK_DIV cycle counter producing the one-second tick.
// Clear has priority over hold; tick/half decode the current count.
module tick_prescaler #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic resetN,
    input  logic i_clr,
    input  logic i_hold,
    output logic o_tick,
    output logic o_half
);

    localparam int W = $clog2(TICK_DIV);

    localparam logic [W-1:0] MAX  = W'(TICK_DIV - 1);
    localparam logic [W-1:0] HALF = W'(TICK_DIV / 2 - 1);

    logic [W-1:0] r_cnt;

    // Count 0..TICK_DIV-1 and wrap; freeze while held
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (!i_hold) begin
            if (r_cnt == MAX) r_cnt <= '0;
            else              r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == MAX);
    assign o_half = (r_cnt == HALF);

endmodule

// File: rtl/match_clock_ctrl.sv
// Match clock controller: load strobe, 1 s enable, match FSM.
// Optional blinking last-ten-seconds warn under LAST_TEN_WARN_EN.
module match_clock_ctrl
    import match_clock_pkg::*;
#(
    parameter int         TICK_DIV = TICK_DIV_DEF,
    parameter logic [3:0] PRESET_H = PRESET_H_DEF,
    parameter logic [3:0] PRESET_L = PRESET_L_DEF
) (
    input logic                clk,
    input logic                resetN,
    match_clock_ctrl_if.master bus
);

    state_t r_state;
    logic   r_loadN;
    logic   r_ena;
    logic   r_running;
    logic   r_paused;
    logic   r_game_over;
    logic   r_warn;

    logic   w_tick;
    logic   w_half;
    logic   w_clr;
    logic   w_hold;
    logic   w_warn_run;

    // A pause landing on the last count holds there, so the
    // pending tick fires right after resume instead of being lost.
    assign w_clr  = (r_state == LOAD);
    assign w_hold = (r_state != RUN) || (bus.pause && w_tick);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_presc (
        .clk    (clk),
        .resetN (resetN),
        .i_clr  (w_clr),
        .i_hold (w_hold),
        .o_tick (w_tick),
        .o_half (w_half)
    );

`ifdef LAST_TEN_WARN_EN
    logic w_warn_on;
    logic w_blink;

    assign w_warn_on  = (bus.countH == 4'd0) && !bus.tc;
    assign w_blink    = (w_tick || w_half) && !w_hold;
    assign w_warn_run = w_warn_on & (r_warn ^ w_blink);
`else
    logic w_unused;

    assign w_warn_run = 1'b0;
    assign w_unused   = ^{bus.countH, w_half};
`endif

    // Match FSM; all control outputs registered with the state
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_state     <= IDLE;
            r_loadN     <= 1'b1;
            r_ena       <= 1'b0;
            r_running   <= 1'b0;
            r_paused    <= 1'b0;
            r_game_over <= 1'b0;
            r_warn      <= 1'b0;
        end else begin
            r_loadN <= 1'b1;
            r_ena   <= 1'b0;
            if (bus.start && r_state != LOAD) begin
                r_state     <= LOAD;
                r_loadN     <= 1'b0;
                r_running   <= 1'b0;
                r_paused    <= 1'b0;
                r_game_over <= 1'b0;
                r_warn      <= 1'b0;
            end else begin
                unique case (r_state)
                    LOAD: begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                    end
                    RUN: begin
                        if (bus.tc) begin
                            r_state     <= OVER;
                            r_running   <= 1'b0;
                            r_game_over <= 1'b1;
                            r_warn      <= 1'b0;
                        end else begin
                            r_ena  <= w_tick && !bus.pause;
                            r_warn <= w_warn_run;
                            if (bus.pause) begin
                                r_state   <= PAUSED;
                                r_running <= 1'b0;
                                r_paused  <= 1'b1;
                            end
                        end
                    end
                    PAUSED: begin
                        if (bus.pause) begin
                            r_state   <= RUN;
                            r_running <= 1'b1;
                            r_paused  <= 1'b0;
                        end
                    end
                    IDLE, OVER: ;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.loadN     = r_loadN;
    assign bus.ena       = r_ena;
    assign bus.datainL   = PRESET_L;
    assign bus.datainH   = PRESET_H;
    assign bus.running   = r_running;
    assign bus.paused    = r_paused;
    assign bus.game_over = r_game_over;
    assign bus.warn      = r_warn;

endmodule
